// File: rtl/incr_stream.sv
// ----------------------------------------------------------------------------
// incr_stream
//
// Streaming incrementer with an output FIFO. Each accepted input word has the
// constant STEP added, either wrapping or saturating on carry-out. The result
// and its overflow flag are queued in a DEPTH-entry FIFO and presented at the
// head on a valid/ready output. A saturating counter tracks how many accepted
// words overflowed.
//
// Ports
//   clk        in   rising-edge clock for all state
//   reset_l    in   asynchronous active-low reset
//   in_valid   in   input word present
//   in_ready   out  a word can be accepted this cycle (FIFO not full)
//   in_data    in   input word, WIDTH bits
//   mode_sat   in   1 = saturate on overflow, 0 = wrap (sampled on push)
//   out_valid  out  FIFO head holds a word
//   out_ready  in   consumer takes the head this cycle
//   out_data   out  head result word, 0 while out_valid = 0
//   out_ovf    out  head overflow flag, 0 while out_valid = 0
//   ovf_count  out  saturating count of overflowing pushes
//   count_clr  in   synchronous clear of ovf_count (wins over an increment)
//   level      out  current FIFO occupancy
//
// Every output is taken directly from a flop. The head word is therefore
// precomputed for the next cycle: when a push lands on the slot the read
// pointer is about to point at, the new entry is forwarded instead of being
// read back from the array.
// ----------------------------------------------------------------------------
module incr_stream #(
    parameter int               WIDTH = 70,
    parameter logic [WIDTH-1:0] STEP  = WIDTH'(1),
    parameter int               DEPTH = 4,
    parameter int               CNT_W = 16,
    parameter int               LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             mode_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             count_clr,
    output logic [LVL_W-1:0] level
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Adds STEP to a word; returns {ovf, result}.
    function automatic logic [WIDTH:0] incr_word(input logic [WIDTH-1:0] din,
                                                 input logic             sat);
        logic [WIDTH:0] sum;
        sum = {1'b0, din} + {1'b0, STEP};
        if (sum[WIDTH]) begin
            if (sat) begin
                incr_word = {1'b1, {WIDTH{1'b1}}};
            end else begin
                incr_word = {1'b1, sum[WIDTH-1:0]};
            end
        end else begin
            incr_word = {1'b0, sum[WIDTH-1:0]};
        end
    endfunction

    // Advances a FIFO pointer, wrapping from DEPTH-1 back to 0.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            ptr_next = {PTR_W{1'b0}};
        end else begin
            ptr_next = p + PTR_W'(1);
        end
    endfunction

    // Storage: each entry is {ovf, result}.
    logic [WIDTH:0]   mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH:0]   head_q, head_d;

    logic             push_s;
    logic             pop_s;
    logic [WIDTH:0]   entry_s;

    // Handshake decode and the incremented entry for the current input.
    always_comb begin
        push_s  = in_valid && in_ready_q;
        pop_s   = out_valid_q && out_ready;
        entry_s = incr_word(in_data, mode_sat);
    end

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = ptr_next(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Overflow counter next-state: clear beats increment, increment saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (count_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (push_s && entry_s[WIDTH] && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Next-cycle output values, so the outputs themselves come from flops.
    always_comb begin
        in_ready_d  = (level_d < LVL_FULL);
        out_valid_d = (level_d != {LVL_W{1'b0}});
        head_d      = {(WIDTH + 1){1'b0}};
        if (level_d == {LVL_W{1'b0}}) begin
            head_d = {(WIDTH + 1){1'b0}};
        end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            // The next head slot is being written this edge: forward it.
            head_d = entry_s;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Control and output registers, cleared asynchronously by reset_l.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            level_q     <= {LVL_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            head_q      <= {(WIDTH + 1){1'b0}};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
        end
    end

    // FIFO array write; contents need no reset because level gates all reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= entry_s;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_q[WIDTH-1:0];
    assign out_ovf   = head_q[WIDTH];
    assign ovf_count = cnt_q;
    assign level     = level_q;

endmodule
